// File: rtl/cache_data_store.sv
// Write-back cache data array: WAYS lines with registered byte/word reads, write hits,
// per-way dirty bits and an evict-then-refill miss sequence toward memory.
module cache_data_store #(
  parameter  int WAYS   = 4,
  parameter  int LINE_W = 128,
  parameter  int ADDR_W = 20,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int OFF_W  = $clog2(LINE_W / 8)
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic [ADDR_W-1:0] read_addr_i,
  input  logic              rqst_byte_i,
  input  logic [WAY_W-1:0]  read_hit_way_i,
  input  logic              write_enable_i,
  input  logic              write_hit_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [WAY_W-1:0]  write_hit_way_i,
  input  logic              write_byte_i,
  input  logic [31:0]       write_data_i,
  input  logic              read_miss_i,
  input  logic [WAY_W-1:0]  lru_way_i,
  output logic              evict_valid_o,
  output logic [LINE_W-1:0] evict_data_o,
  input  logic              evict_ready_i,
  output logic              mem_req_o,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic [31:0]       data_o
);

  localparam int IDX_W = OFF_W + 3;
  // Clearing bit-index bits [4:3] rounds a byte position down to its word.
  localparam logic [IDX_W-1:0] WORD_MASK = ~IDX_W'(24);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EVICT  = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAY_W-1:0]  victim;
  logic [WAYS-1:0]   dirty;
  logic [LINE_W-1:0] lines [WAYS];

  logic              write_go;
  logic              refill_go;
  logic [IDX_W-1:0]  wr_byte_bit;
  logic [IDX_W-1:0]  wr_word_bit;
  logic [IDX_W-1:0]  rd_byte_bit;
  logic [IDX_W-1:0]  rd_word_bit;
  logic [LINE_W-1:0] rd_line;
  logic              unused_addr;

  // Writes are also held off while reset is asserted, since the array has no reset.
  assign write_go    = write_enable_i & write_hit_i & (state == IDLE) & rsn_i;
  assign refill_go   = (state == REFILL) & mem_data_ready_i;
  assign wr_byte_bit = {write_addr_i[OFF_W-1:0], 3'b000};
  assign wr_word_bit = wr_byte_bit & WORD_MASK;
  assign rd_byte_bit = {read_addr_i[OFF_W-1:0], 3'b000};
  assign rd_word_bit = rd_byte_bit & WORD_MASK;
  assign rd_line     = lines[read_hit_way_i];
  assign unused_addr = ^{read_addr_i, write_addr_i};

  assign busy_o        = (state != IDLE);
  assign evict_valid_o = (state == EVICT);
  assign mem_req_o     = (state == REFILL);
  assign evict_data_o  = lines[victim];

  // NOTE: assigning state_nxt before the case gives every path a value, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read_miss_i) state_nxt = dirty[lru_way_i] ? EVICT : REFILL;
      EVICT:   if (evict_ready_i) state_nxt = REFILL;
      REFILL:  if (mem_data_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state  <= IDLE;
      victim <= '0;
      dirty  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && read_miss_i) victim <= lru_way_i;
      if (write_go)  dirty[write_hit_way_i] <= 1'b1;
      if (refill_go) dirty[victim] <= 1'b0;
    end
  end

  // NOTE: the line array is deliberately not reset; contents are valid only once refilled.
  always_ff @(posedge clk_i) begin
    if (refill_go) begin
      lines[victim] <= mem_data_i;
    end else if (write_go) begin
      if (write_byte_i) lines[write_hit_way_i][wr_byte_bit +: 8]  <= write_data_i[7:0];
      else              lines[write_hit_way_i][wr_word_bit +: 32] <= write_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i)           data_o <= '0;
    else if (rqst_byte_i) data_o <= {24'b0, rd_line[rd_byte_bit +: 8]};
    else                  data_o <= rd_line[rd_word_bit +: 32];
  end

endmodule
